// File: rtl/rsa_pkg.sv
// Shared types and helpers for the RSA modular-exponentiation engine.
package rsa_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        EXPCHK,
        MUL,
        UPD,
        FIN
    } state_t;

    localparam int BITLEN_MAX = 1024;

    function automatic int bitlen(input logic [BITLEN_MAX-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < BITLEN_MAX; i++) begin
            if (v[i]) begin
                n = i + 1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/rsa_modmul_serial.sv
// Bit-serial interleaved shift-add modular multiplier, multiplier bits MSB first.
module rsa_modmul_serial
    import rsa_pkg::*;
#(
    parameter int WIDTH = 256
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    input  logic             step,
    output logic [WIDTH-1:0] product,
    output logic             last
);

    localparam int ACC_W = WIDTH + 2;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] mul_q;
    logic [WIDTH-1:0] n_q;
    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;

    logic [ACC_W-1:0] n_ext;
    logic [ACC_W-1:0] a_ext;
    logic [ACC_W-1:0] dbl;
    logic [ACC_W-1:0] red1;
    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] acc_nx;

    // Both intermediates stay below 2n, so WIDTH+2 bits never overflow.
    always_comb begin
        n_ext  = {2'b00, n_q};
        a_ext  = {2'b00, a_q};
        dbl    = acc_q << 1;
        red1   = (dbl >= n_ext) ? dbl - n_ext : dbl;
        sum    = mul_q[WIDTH-1] ? red1 + a_ext : red1;
        acc_nx = (sum >= n_ext) ? sum - n_ext : sum;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q   <= '0;
            mul_q <= '0;
            n_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            a_q   <= a;
            mul_q <= b;
            n_q   <= n;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (step) begin
            acc_q <= acc_nx;
            mul_q <= mul_q << 1;
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign product = acc_q[WIDTH-1:0];
    assign last    = step && (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/rsa_modexp_engine.sv
// Right-to-left square-and-multiply mod-exp with start/busy/done handshake.
module rsa_modexp_engine
    import rsa_pkg::*;
#(
    parameter int WIDTH     = 256,
    parameter int EXP_WIDTH = 256
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     mod_in,
    input  logic [WIDTH-1:0]     msg_in,
    input  logic [EXP_WIDTH-1:0] exp_in,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [WIDTH-1:0]     result
);

    state_t               state;
    logic [WIDTH-1:0]     n_q;
    logic [WIDTH-1:0]     b_q;
    logic [WIDTH-1:0]     r_q;
    logic [EXP_WIDTH-1:0] e_q;
    logic                 err_q;

    logic             mm_load;
    logic             mm_step;
    logic [WIDTH-1:0] rb_prod;
    logic [WIDTH-1:0] bb_prod;
    logic             rb_last;
    logic             bb_last;

    assign mm_load = (state == EXPCHK) && (e_q != '0);
    assign mm_step = (state == MUL);

    rsa_modmul_serial #(.WIDTH(WIDTH)) u_mul_rb (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (mm_load),
        .a       (b_q),
        .b       (r_q),
        .n       (n_q),
        .step    (mm_step),
        .product (rb_prod),
        .last    (rb_last)
    );

    rsa_modmul_serial #(.WIDTH(WIDTH)) u_mul_bb (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (mm_load),
        .a       (b_q),
        .b       (b_q),
        .n       (n_q),
        .step    (mm_step),
        .product (bb_prod),
        .last    (bb_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            result <= '0;
            n_q    <= '0;
            b_q    <= '0;
            r_q    <= '0;
            e_q    <= '0;
            err_q  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        n_q   <= mod_in;
                        b_q   <= msg_in;
                        e_q   <= exp_in;
                        busy  <= 1'b1;
                        state <= PREP;
                    end
                end
                PREP: begin
                    // A range error clears the exponent and exits via EXPCHK.
                    if (n_q == '0 || b_q >= n_q) begin
                        err_q <= 1'b1;
                        r_q   <= '0;
                        e_q   <= '0;
                    end else begin
                        err_q <= 1'b0;
                        r_q   <= (n_q == WIDTH'(1)) ? '0 : WIDTH'(1);
                    end
                    state <= EXPCHK;
                end
                EXPCHK: begin
                    state <= (e_q == '0) ? FIN : MUL;
                end
                MUL: begin
                    if (rb_last && bb_last) begin
                        state <= UPD;
                    end
                end
                UPD: begin
                    b_q <= bb_prod;
                    if (e_q[0]) begin
                        r_q <= rb_prod;
                    end
                    e_q   <= e_q >> 1;
                    state <= EXPCHK;
                end
                FIN: begin
                    result <= r_q;
                    err    <= err_q;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/rsa_modexp_engine.md
Name: rsa_modexp_engine

Overview:
- Parametrised modular-exponentiation engine computing msg_in^exp_in mod mod_in.
- Successor to the fixed-width mod-exp inside the RSA control path. Adds independent exponent width, a start/busy/done handshake, operand-range error detection and early termination at the exponent MSB.
- Sits under the RSA control block. Control supplies the modulus, the message, and e or d depending on encrypt/decrypt.

Parameters:
- WIDTH, 256, modulus/message/result width in bits.
- EXP_WIDTH, 256, exponent width in bits.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request; accepted only while busy=0.
- mod_in  input  WIDTH  modulus n, sampled at accept.
- msg_in  input  WIDTH  base m, sampled at accept.
- exp_in  input  EXP_WIDTH  exponent, sampled at accept.
- busy  output  1  high from the cycle after accept until done.
- done  output  1  one-cycle completion pulse.
- err  output  1  range error flag, valid with done, held with result.
- result  output  WIDTH  m^e mod n, held stable until the next accept.

Behaviour:
Reset (reset_n=0, asynchronous, any time including mid-operation):
- state=IDLE; busy=0, done=0, err=0, result=0.
- All internal registers cleared; the in-flight operation is discarded.

Accept and ignore rules:
- Accept = rising edge with start=1 and busy=0. Inputs are registered at that edge.
- start while busy=1 is ignored, with no effect on the operation.

States:
- IDLE: wait for accept, then go to PREP.
- PREP, 1 cycle:
  - If n==0 or m>=n: go to FIN with err=1 and result=0.
  - Else: r = (n==1 ? 0 : 1); b = m; e_reg = exp.
  - Go to EXPCHK.
- EXPCHK, 1 cycle:
  - If e_reg==0: go to FIN.
  - Else start two parallel modmuls, r*b and b*b, then go to MUL.
- MUL, exactly WIDTH cycles: one multiplier bit per cycle, MSB first.
- UPD, 1 cycle:
  - b = b*b mod n.
  - If e_reg[0], r = r*b mod n (using the old b).
  - e_reg >>= 1; go to EXPCHK.
- FIN, 1 cycle: result=r; done=1 and busy=0 on the following cycle; return to IDLE.

Latency:
- k = index of highest set exponent bit + 1 (k=0 for exponent 0).
- done asserts exactly 3 + k*(WIDTH+2) cycles after the accepting edge.
- Error case: 3 cycles.

Back-to-back operation:
- start may be high in the same cycle as done; it is accepted at that edge.
- result and err update only at the next FIN.

Modmul step (interleaved shift-add; a < n and b < n guaranteed):
- acc = 2*acc; if acc >= n then acc -= n.
- If bit, acc += a; if acc >= n then acc -= n.
- Internal width WIDTH+2 bits; no truncation before compare.

Boundary behaviour:
- n==1 gives result 0.
- Exponent 0 with n>1 gives result 1.
- m==0 with exponent >0 gives result 0.
- Exponent all ones processes EXP_WIDTH iterations.

Decomposition:
Package rsa_pkg:
- State enum: IDLE, PREP, EXPCHK, MUL, UPD, FIN.
- Constant ACC_W = WIDTH+2, as a localparam derived in the module.
- Function bitlen() for bench latency checks.

Sub-module rsa_modmul_serial:
- Bit-serial modular multiplier, WIDTH-parameterised.
- Ports: load, a, b, n, step, product, last.
- Instantiated twice, for r*b and b*b.

Test Plan:
1. WIDTH=8, EXP_WIDTH=8; n=187, m=88, e=7 -> result=11, err=0, done exactly 33 cycles after accept (k=3).
2. Decrypt from case 1: n=187, m=11, e=23 -> result=88; latency 3+5*10=53.
3. Exponent 0 (n=187, m=88) -> result=1 in 3 cycles. Then n=1, m=0, e=5 -> result=0.
4. Errors:
   - n=0 -> err=1, result=0, done 3 cycles after accept.
   - n=187, m=200 -> err=1.
   - The next valid op clears err.
5. Robustness: start pulsed during MUL is ignored. reset_n dropped mid-MUL -> busy=0, done=0, result=0 immediately (asynchronous). A fresh op after release gives the correct result.
6. WIDTH=128, EXP_WIDTH=128: two-op metamorphic check.
   - n = 113680897410347*7999808077935876437321, e=65537, d from the inverter, msg=128'h3ab37b2857e7e149.
   - Encrypt then decrypt, with start held high across done -> decrypted output equals msg.
